// File: rtl/branch_pc_ctrl.sv
// Branch sequencer and PC owner: decodes a branch, drives Ra and the CON strobe,
// then conditionally applies the signed IR offset to the program counter.
module branch_pc_ctrl #(
    parameter int unsigned          PC_WIDTH  = 32,
    parameter logic [4:0]           BR_OPCODE = 5'b10010,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                start,
    input  logic                inc_pc,
    input  logic [31:0]         ir,
    input  logic                con_out,
    output logic [1:0]          con_ir_bits,
    output logic                con_in,
    output logic                gra_rout,
    output logic [3:0]          ra_sel,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                busy,
    output logic                taken,
    output logic                illegal,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        SETTLE,
        DECIDE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [4:0]          opcode_q;
    logic [18:0]         offset_q;
    logic [PC_WIDTH-1:0] offset_ext;
    logic                is_branch;
    logic                unused_ir;

    assign unused_ir  = ^ir[22:21];
    assign is_branch  = (opcode_q == BR_OPCODE);
    assign offset_ext = {{(PC_WIDTH-19){offset_q[18]}}, offset_q};
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are decoded straight from state so they can never glitch
    // across more than the single intended cycle.
    always_comb begin
        state_d  = state_q;
        con_in   = 1'b0;
        gra_rout = 1'b0;
        done     = 1'b0;
        illegal  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = EVAL;
            end
            EVAL: begin
                if (is_branch) begin
                    gra_rout = 1'b1;
                    con_in   = 1'b1;
                    state_d  = SETTLE;
                end else begin
                    state_d  = DONE;
                end
            end
            SETTLE: begin
                gra_rout = 1'b1;
                state_d  = DECIDE;
            end
            DECIDE: begin
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                illegal = ~is_branch;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            pc_out      <= RESET_PC;
            taken       <= 1'b0;
            con_ir_bits <= 2'b00;
            ra_sel      <= 4'd0;
            opcode_q    <= 5'd0;
            offset_q    <= 19'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        opcode_q    <= ir[31:27];
                        ra_sel      <= ir[26:23];
                        con_ir_bits <= ir[20:19];
                        offset_q    <= ir[18:0];
                    end else if (inc_pc) begin
                        pc_out <= pc_out + PC_WIDTH'(1);
                    end
                end
                DECIDE: begin
                    taken <= con_out;
                    if (con_out) pc_out <= pc_out + offset_ext;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Directed bench for branch_pc_ctrl: hand-computed PC, strobe and timing checks.
module tb_branch_pc_ctrl;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic        inc_pc;
    logic [31:0] ir;
    logic        con_out;
    logic [1:0]  con_ir_bits;
    logic        con_in;
    logic        gra_rout;
    logic [3:0]  ra_sel;
    logic [31:0] pc_out;
    logic        busy;
    logic        taken;
    logic        illegal;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt;

    always #5 clk = ~clk;

    branch_pc_ctrl dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .inc_pc      (inc_pc),
        .ir          (ir),
        .con_out     (con_out),
        .con_ir_bits (con_ir_bits),
        .con_in      (con_in),
        .gra_rout    (gra_rout),
        .ra_sel      (ra_sel),
        .pc_out      (pc_out),
        .busy        (busy),
        .taken       (taken),
        .illegal     (illegal),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic inc_n(input int n);
        inc_pc = 1'b1;
        repeat (n) step();
        inc_pc = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op,
                                          input logic [3:0] ra,
                                          input logic [1:0] c2,
                                          input logic [18:0] off);
        return {op, ra, 2'b00, c2, off};
    endfunction

    initial begin
        clear   = 1'b1;
        start   = 1'b0;
        inc_pc  = 1'b0;
        ir      = '0;
        con_out = 1'b0;
        step();
        step();
        check("rst_pc", pc_out, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_taken", 32'(taken), 32'h0);
        check("rst_strobes", {28'h0, con_in, gra_rout, done, illegal}, 32'h0);
        check("rst_fields", {26'h0, con_ir_bits, ra_sel}, 32'h0);
        clear = 1'b0;

        // Clear asserted mid-SETTLE aborts the branch
        inc_n(16);
        check("pc_0x10", pc_out, 32'h10);
        ir      = mk_ir(5'b10010, 4'd3, 2'b01, 19'd5);
        con_out = 1'b1;
        start   = 1'b1;
        step();
        start = 1'b0;
        check("abort_eval_con_in", 32'(con_in), 32'h1);
        step();
        check("abort_settle_con_in", 32'(con_in), 32'h0);
        check("abort_settle_gra", 32'(gra_rout), 32'h1);
        clear = 1'b1;
        #1;
        check("abort_pc", pc_out, 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_con_in", 32'(con_in), 32'h0);
        step();
        clear = 1'b0;
        cnt = 0;
        repeat (6) begin
            step();
            if (done) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'h0);
        check("abort_pc_held", pc_out, 32'h0);

        // brzr taken at PC=0x20, offset +5
        inc_n(32);
        check("pc_0x20", pc_out, 32'h20);
        ir      = mk_ir(5'b10010, 4'd5, 2'b00, 19'd5);
        con_out = 1'b1;
        start   = 1'b1;
        step();
        start = 1'b0;
        cnt   = 0;
        check("brzr_eval_con_in", 32'(con_in), 32'h1);
        check("brzr_eval_gra", 32'(gra_rout), 32'h1);
        check("brzr_bits", 32'(con_ir_bits), 32'h0);
        check("brzr_ra", 32'(ra_sel), 32'h5);
        check("brzr_busy", 32'(busy), 32'h1);
        if (con_in) cnt++;
        step();
        if (con_in) cnt++;
        check("brzr_settle_gra", 32'(gra_rout), 32'h1);
        step();
        if (con_in) cnt++;
        check("brzr_decide_done", 32'(done), 32'h0);
        check("brzr_decide_pc", pc_out, 32'h20);
        step();
        if (con_in) cnt++;
        check("brzr_done", 32'(done), 32'h1);
        check("brzr_illegal", 32'(illegal), 32'h0);
        check("brzr_pc", pc_out, 32'h25);
        check("brzr_taken", 32'(taken), 32'h1);
        step();
        check("brzr_con_in_cycles", 32'(cnt), 32'h1);
        check("brzr_idle_done", 32'(done), 32'h0);
        check("brzr_idle_busy", 32'(busy), 32'h0);

        // brmi not taken at PC=0x40, offset -3, inc_pc held while busy
        inc_n(27);
        check("pc_0x40", pc_out, 32'h40);
        ir      = mk_ir(5'b10010, 4'd9, 2'b11, 19'h7FFFD);
        con_out = 1'b0;
        start   = 1'b1;
        step();
        start  = 1'b0;
        inc_pc = 1'b1;
        check("brmi_bits", 32'(con_ir_bits), 32'h3);
        step();
        check("brmi_settle_bits", 32'(con_ir_bits), 32'h3);
        step();
        check("brmi_decide_bits", 32'(con_ir_bits), 32'h3);
        step();
        check("brmi_done", 32'(done), 32'h1);
        check("brmi_taken", 32'(taken), 32'h0);
        check("brmi_pc", pc_out, 32'h40);
        step();
        inc_pc = 1'b0;
        check("brmi_busy_inc_ignored", pc_out, 32'h40);
        check("brmi_idle", 32'(busy), 32'h0);

        // Negative wrap: PC=1, offset -2
        do_clear();
        inc_n(1);
        check("pc_1", pc_out, 32'h1);
        ir      = mk_ir(5'b10010, 4'd1, 2'b10, 19'h7FFFE);
        con_out = 1'b1;
        start   = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("wrap_done", 32'(done), 32'h1);
        check("wrap_pc", pc_out, 32'hFFFF_FFFF);
        check("wrap_taken", 32'(taken), 32'h1);
        step();

        // Illegal opcode: done two cycles after start, no strobes
        ir    = mk_ir(5'b00011, 4'd2, 2'b01, 19'd100);
        start = 1'b1;
        step();
        start = 1'b0;
        check("ill_eval_strobes", {30'h0, con_in, gra_rout}, 32'h0);
        check("ill_eval_done", 32'(done), 32'h0);
        check("ill_busy", 32'(busy), 32'h1);
        step();
        check("ill_flags", {30'h0, illegal, done}, 32'h3);
        check("ill_pc", pc_out, 32'hFFFF_FFFF);
        step();
        check("ill_after", {30'h0, illegal, done}, 32'h0);

        // Priority: start beats inc_pc at PC=7
        do_clear();
        inc_n(7);
        check("pc_7", pc_out, 32'h7);
        start  = 1'b1;
        inc_pc = 1'b1;
        step();
        start  = 1'b0;
        inc_pc = 1'b0;
        check("prio_pc", pc_out, 32'h7);
        step();
        step();
        inc_n(1);
        check("inc_idle_pc", pc_out, 32'h8);

        // Most negative offset: 8 - 262144
        ir      = mk_ir(5'b10010, 4'd4, 2'b00, 19'h40000);
        con_out = 1'b1;
        start   = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("maxneg_pc", pc_out, 32'hFFFC_0008);
        step();

        // Taken with zero offset leaves PC alone
        ir    = mk_ir(5'b10010, 4'd4, 2'b00, 19'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("zero_off_pc", pc_out, 32'hFFFC_0008);
        check("zero_off_taken", 32'(taken), 32'h1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_pc_ctrl.md
Name: branch_pc_ctrl

Overview:
- Sequencer and program-counter owner for conditional branch instructions (br, brzr/brnz/brpl/brmi).
- On start it decodes IR, places Ra on the bus, strobes the CON flip-flop with the IR condition field, samples the resulting CON result, and conditionally loads PC with PC + sign-extended offset.
- Sits directly around the CON flip-flop stage:
  - upstream: drives its IR condition bits and CON_in strobe;
  - downstream: consumes CON_out.
- Also services plain PC increment during fetch.

Parameters:
- PC_WIDTH, 32, width of PC and bus.
- BR_OPCODE, 5'b10010, opcode value IR[31:27] identifying a branch instruction.
- RESET_PC, 32'h0000_0000, PC value on clear.

Ports:
- clk  input  1  system clock, rising-edge.
- clear  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to execute the branch held in ir; ignored unless idle.
- inc_pc  input  1  PC <= PC + 1 on next edge; honoured only when idle and start low.
- ir  input  32  instruction: [31:27] opcode, [26:23] Ra, [20:19] C2 condition, [18:0] signed offset C.
- con_out  input  1  result from CON flip-flop.
- con_ir_bits  output  2  condition code to CON stage (IR[20:19] latched at start).
- con_in  output  1  CON flip-flop strobe.
- gra_rout  output  1  select Ra onto bus.
- ra_sel  output  4  Ra register number (latched).
- pc_out  output  32  current PC.
- busy  output  1  high from the cycle after an accepted start until the cycle DONE is exited.
- taken  output  1  result of the last branch; holds until the next accepted start.
- illegal  output  1  one-cycle pulse in DONE when the latched opcode was not BR_OPCODE.
- done  output  1  one-cycle pulse in the DONE state.

Behaviour:
- Reset (clear high, asynchronous):
  - state=IDLE, pc_out=RESET_PC, taken=0.
  - All strobes 0: con_in, gra_rout, done, illegal.
  - con_ir_bits=0, ra_sel=0.
  - Clear mid-operation aborts immediately; no PC update.
- State IDLE:
  - start=1: latch opcode, ra_sel=IR[26:23], con_ir_bits=IR[20:19], offset=IR[18:0]; go to EVAL.
  - Otherwise, if inc_pc=1: PC <= PC+1 (mod 2^32).
  - start has priority over inc_pc in the same cycle; inc_pc is dropped.
- State EVAL (1 cycle):
  - Latched opcode != BR_OPCODE: go to DONE with illegal flagged; no strobes asserted.
  - Otherwise gra_rout=1, con_in=1; go to SETTLE.
- State SETTLE (1 cycle):
  - gra_rout=1, con_in=0, so bus is held while CON captures and settles.
  - Go to DECIDE.
- State DECIDE (1 cycle):
  - Sample con_out: taken <= con_out.
  - If con_out=1: PC <= PC + sign_extend_32(offset), wrap modulo 2^32.
  - Go to DONE.
- State DONE (1 cycle):
  - done=1; illegal=1 if flagged; go to IDLE.
- Timing and strobe rules:
  - Latency from the start edge to the done pulse is 4 cycles for a legal branch, 2 cycles for an illegal one.
  - start and inc_pc are ignored while busy; no queuing.
  - con_in is high for exactly one clock per legal branch. The CON stage is level-sensitive, so a multi-cycle or glitching con_in is forbidden.
  - con_ir_bits is stable from EVAL through DECIDE.
- Offset arithmetic:
  - The offset is applied to the PC value current at DECIDE (already incremented by fetch).
  - Offset 0 with taken=1 leaves PC unchanged.
  - Maximum negative offset is -262144.

Test Plan:
- Reset: assert clear mid-SETTLE with PC=0x10 -> pc_out=0, busy=0, con_in=0 immediately; no later done pulse.
- brzr taken: PC=0x20, ir opcode 10010, C2=00, offset=+5, con_out=1 at DECIDE -> con_in high exactly one cycle in EVAL, con_ir_bits=00, done 4 cycles after start, pc_out=0x25, taken=1.
- brmi not taken: PC=0x40, C2=11, offset=-3, con_out=0 -> pc_out stays 0x40, taken=0, done pulses.
- Negative wrap: PC=0x0000_0001, offset=-2, con_out=1 -> pc_out=0xFFFF_FFFF.
- Illegal opcode 00011 with start -> no con_in/gra_rout, illegal=1 and done=1 in the same cycle 2 cycles after start, PC unchanged.
- Priority: start and inc_pc together at PC=7 -> PC not incremented. inc_pc during busy -> ignored. inc_pc in IDLE -> pc_out=8 next cycle.
